// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, frame-atomic arbiter sharing one uart_tx byte channel
//            between N_REQ producers through a one-byte output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int TIMEOUT_CYC   = 1023,
  localparam int GW           = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [GW-1:0]      grant_id,
  output logic               grant_active,
  output logic               timeout_pulse
);

  localparam int            CW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] c_tmax    = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [GW-1:0] c_last_id = GW'(N_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_grant_id;
  logic [GW-1:0] w_grant_id_nxt;
  logic [CW-1:0] r_tcnt;
  logic [CW-1:0] w_tcnt_nxt;
  logic          r_pulse;
  logic          w_pulse_nxt;
  logic          r_buf_full;
  logic [7:0]    r_buf_data;

  logic          w_sel_valid;
  logic          w_sel_last;
  logic [7:0]    w_sel_data;
  logic          w_ready_g;
  logic          w_accept;
  logic          w_timeout;
  logic          w_found;
  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_idx;

  assign w_sel_valid = req_valid[r_grant_id];
  assign w_sel_last  = req_last[r_grant_id];
  assign w_sel_data  = req_data[{r_grant_id, 3'b000} +: 8];

  // Round-robin search starts one past the previous holder; the holder itself is checked last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_grant_id;
    w_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = GW'((int'(r_grant_id) + k) % N_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_id_nxt = r_grant_id;
    w_tcnt_nxt     = r_tcnt;
    w_pulse_nxt    = 1'b0;
    w_ready_g      = 1'b0;
    w_accept       = 1'b0;
    w_timeout      = 1'b0;
    req_ready      = '0;
    case (r_state)
      ST_IDLE: begin
        w_tcnt_nxt = '0;
        if (w_found) begin
          w_grant_id_nxt = w_pick;
          w_state_nxt    = ST_OWN;
        end
      end
      ST_OWN: begin
        w_ready_g             = ~r_buf_full | tx_ready;
        req_ready[r_grant_id] = w_ready_g;
        w_accept              = w_ready_g & w_sel_valid;
        // Only cycles with no byte offered count; a byte held off by backpressure does not.
        w_timeout             = (TIMEOUT_CYC != 0) && !w_sel_valid && (r_tcnt == c_tmax);
        if (w_accept) begin
          w_tcnt_nxt = '0;
          if (w_sel_last) begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_timeout) begin
          w_tcnt_nxt  = '0;
          w_pulse_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!w_sel_valid) begin
          w_tcnt_nxt = r_tcnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant_id <= c_last_id;
      r_tcnt     <= '0;
      r_pulse    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_pulse    <= w_pulse_nxt;
    end
  end

  // Accept has priority over consume so a simultaneous pair reloads the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full <= 1'b0;
      r_buf_data <= '0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf_data <= w_sel_data;
    end else if (tx_ready) begin
      r_buf_full <= 1'b0;
    end
  end

  assign tx_valid      = r_buf_full;
  assign tx_data       = r_buf_data;
  assign grant_id      = r_grant_id;
  assign grant_active  = (r_state == ST_OWN);
  assign timeout_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter: queue-based reference model,
//            directed frame scenarios and a randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam int TMO   = 8;

  logic                 clk;
  logic                 rst_n;
  logic [N_REQ-1:0]     req_valid;
  logic [8*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]     req_last;
  logic [N_REQ-1:0]     req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic [1:0]           grant_id;
  logic                 grant_active;
  logic                 timeout_pulse;

  uart_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .grant_active(grant_active), .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_q(input string nm, input logic [7:0] act[$], input logic [7:0] exp[$]);
    check({nm, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++) check(nm, act[i], exp[i]);
  endtask

  // Producers: one queue of {last,data} per requester
  logic [8:0]       q [N_REQ][$];
  logic [N_REQ-1:0] fire = '0;
  bit               rand_mode = 1'b0;
  logic             tx_ready_dir = 1'b1;
  logic             tx_ready_rnd = 1'b1;
  int               pause [N_REQ];
  int               rlen;

  assign tx_ready = rand_mode ? tx_ready_rnd : tx_ready_dir;

  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < N_REQ; i++) pause[i] = 0;
  end

  always begin
    @(posedge clk); #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (!rst_n) q[i].delete();
      else if (fire[i] && q[i].size() > 0) void'(q[i].pop_front());
      if (rand_mode && q[i].size() == 0) begin
        rlen = $urandom_range(1, 4);
        for (int k = 0; k < rlen; k++) q[i].push_back({k == rlen - 1, 8'($urandom)});
      end
      if (pause[i] > 0) pause[i]--;
      else if (rand_mode && $urandom_range(0, 63) == 0) pause[i] = 12;
      req_valid[i] = (q[i].size() > 0) &&
                     (!rand_mode || (pause[i] == 0 && $urandom_range(0, 3) != 0));
      req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0][7:0] : 8'h00;
      req_last[i]        = (q[i].size() > 0) ? q[i][0][8] : 1'b0;
    end
    tx_ready_rnd = ($urandom_range(0, 3) != 0);
  end

  // Reference model: owner (-1 = none), round-robin pointer, idle counter, buffer queue
  int         m_owner = -1;
  int         m_ptr   = N_REQ - 1;
  int         m_idle  = 0;
  bit         m_pulse = 1'b0;
  logic [7:0] m_buf[$];
  bit         m_acc, m_cons;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = N_REQ - 1; m_idle = 0; m_pulse = 1'b0; m_buf.delete();
    end else begin
      m_acc   = (m_owner >= 0) && req_valid[m_owner] && (m_buf.size() == 0 || tx_ready);
      m_cons  = (m_buf.size() > 0) && tx_ready;
      m_pulse = 1'b0;
      if (m_cons) void'(m_buf.pop_front());
      if (m_acc) m_buf.push_back(req_data[8*m_owner +: 8]);
      if (m_owner < 0) begin
        m_idle = 0;
        for (int k = 1; k <= N_REQ; k++)
          if (m_owner < 0 && req_valid[(m_ptr + k) % N_REQ]) m_owner = (m_ptr + k) % N_REQ;
        if (m_owner >= 0) m_ptr = m_owner;
      end else if (m_acc) begin
        m_idle = 0;
        if (req_last[m_owner]) m_owner = -1;
      end else if (!req_valid[m_owner]) begin
        m_idle++;
        if (TMO != 0 && m_idle == TMO) begin
          m_pulse = 1'b1; m_owner = -1; m_idle = 0;
        end
      end
    end
  end

  // Compare process plus logs used by the directed scenarios
  int               cyc = 0;
  logic [7:0]       tx_log[$];
  logic [7:0]       gnt_log[$];
  logic [7:0]       expq[$];
  logic [N_REQ-1:0] exp_ready;
  logic [8:0]       exp_b;
  int               open_frame = -1;
  bit               prev_ga = 1'b0;
  int               first_valid_cyc = -1, first_txv_cyc = -1, ga_fall_cyc = -1;
  int               last_last_cyc = -1, pulse_cyc = -1, pulse_cnt = 0;
  int               last_fire_cyc [N_REQ];

  always @(negedge clk) begin
    cyc++;
    exp_ready = '0;
    if (m_owner >= 0 && (m_buf.size() == 0 || tx_ready)) exp_ready[m_owner] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("tx_valid", tx_valid, m_buf.size() > 0);
    if (m_buf.size() > 0) check("tx_data", tx_data, m_buf[0]);
    check("grant_id", grant_id, m_ptr);
    check("grant_active", grant_active, m_owner >= 0);
    check("timeout_pulse", timeout_pulse, m_pulse);
    check("ready_owner", req_ready & ~(4'b0001 << grant_id), 0);

    if (!rst_n) begin
      tx_log.delete(); gnt_log.delete(); expq.delete();
      open_frame = -1; prev_ga = 1'b0; fire = '0;
      first_valid_cyc = -1; first_txv_cyc = -1; ga_fall_cyc = -1;
      last_last_cyc = -1; pulse_cyc = -1; pulse_cnt = 0;
      for (int i = 0; i < N_REQ; i++) last_fire_cyc[i] = -1;
    end else begin
      if (first_valid_cyc < 0 && req_valid != '0) first_valid_cyc = cyc;
      if (first_txv_cyc < 0 && tx_valid) first_txv_cyc = cyc;
      if (timeout_pulse) begin
        pulse_cnt++; pulse_cyc = cyc; open_frame = -1;
      end
      if (tx_valid && tx_ready) begin
        tx_log.push_back(tx_data);
        exp_b = (expq.size() > 0) ? {1'b0, expq.pop_front()} : 9'h100;
        check("sb_order", {1'b0, tx_data}, exp_b);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          expq.push_back(req_data[8*i +: 8]);
          if (open_frame >= 0) check("frame_atomic", i, open_frame);
          open_frame = req_last[i] ? -1 : i;
          last_fire_cyc[i] = cyc;
          if (req_last[i]) last_last_cyc = cyc;
        end
      end
      fire = req_valid & req_ready;
      if (grant_active && !prev_ga) gnt_log.push_back(8'(grant_id));
      if (!grant_active && prev_ga) ga_fall_cyc = cyc;
      prev_ga = grant_active;
    end
  end

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int i = 0; i < N_REQ; i++) if (q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      done = !tx_valid && !grant_active && (req_valid == '0) && queues_empty();
    end
    check("drain_done", done, 1);
  endtask

  task automatic push_frame(input int i, input logic [7:0] b[$]);
    for (int k = 0; k < b.size(); k++) q[i].push_back({k == b.size() - 1, b[k]});
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [7:0] e[$];
  int         wait_k;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 3);
    check("rst_grant_active", grant_active, 0);
    check("rst_timeout_pulse", timeout_pulse, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single frame from requester 0
    e = '{8'h41, 8'h42, 8'h43}; push_frame(0, e);
    wait_idle(100);
    check_q("s1_tx", tx_log, e);
    check("s1_latency", first_txv_cyc - first_valid_cyc, 2);
    check("s1_release", ga_fall_cyc - last_last_cyc, 1);

    // Round-robin between requesters 0 and 2
    do_reset();
    e = '{8'hA0, 8'hA1}; push_frame(0, e);
    e = '{8'hA2, 8'hA3}; push_frame(0, e);
    e = '{8'hC0, 8'hC1}; push_frame(2, e);
    e = '{8'hC2, 8'hC3}; push_frame(2, e);
    wait_idle(200);
    e = '{8'd0, 8'd2, 8'd0, 8'd2};
    check_q("s2_gnt", gnt_log, e);
    e = '{8'hA0, 8'hA1, 8'hC0, 8'hC1, 8'hA2, 8'hA3, 8'hC2, 8'hC3};
    check_q("s2_tx", tx_log, e);

    // Backpressure mid-frame
    do_reset();
    tx_ready_dir = 1'b1;
    e = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55}; push_frame(0, e);
    wait_k = 0;
    while (!tx_valid && wait_k < 20) begin @(negedge clk); wait_k++; end
    check("s3_start", tx_valid, 1);
    @(posedge clk); #1 tx_ready_dir = 1'b0;
    begin
      logic [7:0] held;
      held = 8'h00;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check("s3_txvalid", tx_valid, 1);
        check("s3_ready", req_ready, 0);
        if (k == 0) held = tx_data;
        else check("s3_txdata", tx_data, held);
      end
    end
    @(posedge clk); #1 tx_ready_dir = 1'b1;
    wait_idle(100);
    check_q("s3_tx", tx_log, e);

    // Stall timeout: requester 1 abandons its frame, requester 3 waits
    do_reset();
    q[1].push_back({1'b0, 8'h10});
    e = '{8'h30, 8'h31}; push_frame(3, e);
    wait_idle(200);
    check("s4_pulses", pulse_cnt, 1);
    check("s4_pulse_delay", pulse_cyc - last_fire_cyc[1], 9);
    e = '{8'd1, 8'd3};
    check_q("s4_gnt", gnt_log, e);
    e = '{8'h10, 8'h30, 8'h31};
    check_q("s4_tx", tx_log, e);

    // Asynchronous reset with the buffer full
    do_reset();
    tx_ready_dir = 1'b0;
    e = '{8'h61, 8'h62, 8'h63}; push_frame(0, e);
    repeat (6) @(negedge clk);
    check("s5_full", tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("s5_async_txvalid", tx_valid, 0);
    check("s5_async_ready", req_ready, 0);
    check("s5_async_ga", grant_active, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tx_ready_dir = 1'b1;
    for (int i = 0; i < N_REQ; i++) q[i].push_back({1'b1, 8'(8'h70 + i)});
    wait_idle(200);
    e = '{8'd0, 8'd1, 8'd2, 8'd3};
    check_q("s5_gnt", gnt_log, e);
    e = '{8'h70, 8'h71, 8'h72, 8'h73};
    check_q("s5_tx", tx_log, e);

    // Random traffic
    do_reset();
    rand_mode = 1'b1;
    repeat (10000) @(posedge clk);
    #1 rand_mode = 1'b0;
    tx_ready_dir = 1'b1;
    wait_idle(3000);
    check("s6_sb_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
